// File: rtl/sa_ctrl_pkg.sv
// Shared encoding and helpers for the systolic array controller and datapath.
// Phase lengths are window sizes modulo the SRAM bank depth.
package sa_ctrl_pkg;

  localparam int LOG2_SRAM_BANK_DEPTH = 5;
  localparam int CNT_WIDTH            = LOG2_SRAM_BANK_DEPTH + 1;
  localparam int CTRL_WIDTH           = 4;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WARMUP = 2'd1;
  localparam logic [1:0] STEADY = 2'd2;
  localparam logic [1:0] DRAIN  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_WARMUP = WARMUP,
    ST_STEADY = STEADY,
    ST_DRAIN  = DRAIN
  } state_e;

  function automatic int drain_cycles(input int num_row, input int num_col);
    return num_row + num_col - 1;
  endfunction

  // end < start wraps through the top of the bank; start == end + 1 is a full bank.
  function automatic logic [CNT_WIDTH-1:0] win_len(
    input logic [LOG2_SRAM_BANK_DEPTH-1:0] start_addr,
    input logic [LOG2_SRAM_BANK_DEPTH-1:0] end_addr
  );
    logic [LOG2_SRAM_BANK_DEPTH-1:0] diff;
    diff = end_addr - start_addr;
    return CNT_WIDTH'(diff) + CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/sa_phase_counter.sv
// Phase down-counter: load, decrement (saturating at zero), clear, zero flag.
module sa_phase_counter #(
  parameter int CNT_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 dec,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_WIDTH'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/systolic_array_ctrl.sv
// Phase sequencer for systolic_array_top: accepts one tile command, walks
// WARMUP/STEADY/DRAIN with exact lengths, and reports done or aborted.
module systolic_array_ctrl #(
  parameter int NUM_ROW              = 4,
  parameter int NUM_COL              = 4,
  parameter int LOG2_SRAM_BANK_DEPTH = 5,
  parameter int CTRL_WIDTH           = 4,
  parameter int CNT_WIDTH            = LOG2_SRAM_BANK_DEPTH + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_cmd_valid,
  output logic                            o_cmd_ready,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_top_start_addr,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_top_end_addr,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_left_start_addr,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_left_end_addr,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_down_start_addr,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_down_end_addr,
  input  logic                            i_abort,
  output logic [CTRL_WIDTH-1:0]           o_ctrl_state,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_sram_rd_end_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_sram_rd_end_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_sram_rd_end_addr,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_aborted
);

  import sa_ctrl_pkg::state_e;
  import sa_ctrl_pkg::ST_IDLE;
  import sa_ctrl_pkg::ST_WARMUP;
  import sa_ctrl_pkg::ST_STEADY;
  import sa_ctrl_pkg::ST_DRAIN;
  import sa_ctrl_pkg::win_len;
  import sa_ctrl_pkg::drain_cycles;

  localparam logic [CNT_WIDTH-1:0] DRAIN_LOAD = CNT_WIDTH'(drain_cycles(NUM_ROW, NUM_COL) - 1);

  state_e               state;
  logic                 accept;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic                 cnt_clr;
  logic [CNT_WIDTH-1:0] cnt_val;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 cnt_zero;

  assign accept       = (state == ST_IDLE) && i_cmd_valid && o_cmd_ready;
  assign o_ctrl_state = {{(CTRL_WIDTH-2){1'b0}}, state};

  // Counters hold len-1 so a phase leaves on the edge where the count reads zero.
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_clr  = 1'b0;
    cnt_val  = '0;
    if (accept) begin
      cnt_load = 1'b1;
      cnt_val  = win_len(i_top_start_addr, i_top_end_addr) - CNT_WIDTH'(1);
    end else if (state != ST_IDLE) begin
      if (i_abort) begin
        cnt_clr = 1'b1;
      end else if (cnt_zero) begin
        case (state)
          ST_WARMUP: begin
            cnt_load = 1'b1;
            cnt_val  = win_len(o_left_sram_rd_start_addr, o_left_sram_rd_end_addr) - CNT_WIDTH'(1);
          end
          ST_STEADY: begin
            cnt_load = 1'b1;
            cnt_val  = DRAIN_LOAD;
          end
          default: ;
        endcase
      end else begin
        cnt_dec = 1'b1;
      end
    end
  end

  sa_phase_counter #(.CNT_WIDTH(CNT_WIDTH)) u_phase_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .clr      (cnt_clr),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                     <= ST_IDLE;
      o_cmd_ready               <= 1'b0;
      o_busy                    <= 1'b0;
      o_done                    <= 1'b0;
      o_aborted                 <= 1'b0;
      o_top_sram_rd_start_addr  <= '0;
      o_top_sram_rd_end_addr    <= '0;
      o_left_sram_rd_start_addr <= '0;
      o_left_sram_rd_end_addr   <= '0;
      o_down_sram_rd_start_addr <= '0;
      o_down_sram_rd_end_addr   <= '0;
    end else begin
      o_done    <= 1'b0;
      o_aborted <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state                     <= ST_WARMUP;
            o_busy                    <= 1'b1;
            o_cmd_ready               <= 1'b0;
            o_top_sram_rd_start_addr  <= i_top_start_addr;
            o_top_sram_rd_end_addr    <= i_top_end_addr;
            o_left_sram_rd_start_addr <= i_left_start_addr;
            o_left_sram_rd_end_addr   <= i_left_end_addr;
            o_down_sram_rd_start_addr <= i_down_start_addr;
            o_down_sram_rd_end_addr   <= i_down_end_addr;
          end else begin
            o_cmd_ready <= 1'b1;
          end
        end
        default: begin
          if (i_abort) begin
            state       <= ST_IDLE;
            o_busy      <= 1'b0;
            o_cmd_ready <= 1'b1;
            o_aborted   <= 1'b1;
          end else if (cnt_zero) begin
            case (state)
              ST_WARMUP: state <= ST_STEADY;
              ST_STEADY: state <= ST_DRAIN;
              default: begin
                state       <= ST_IDLE;
                o_busy      <= 1'b0;
                o_cmd_ready <= 1'b1;
                o_done      <= 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
